// File: rtl/add_arb_pkg.sv
// Shared definitions for the two-requester add arbiter: default widths,
// the output-slot state type and the requester identifier type.
package add_arb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Output slot occupancy: EMPTY means res_valid=0, FULL means res_valid=1.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  // Identifies which requester produced a result or won a grant.
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage : add_arb_pkg

// File: rtl/add_core.sv
// Purely combinational unsigned adder: {carry, sum} = a + b.
module add_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Zero-extend both operands so the top bit of the result is the carry-out.
  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule : add_core

// File: rtl/add_arbiter.sv
// Two requesters share one adder. A round-robin grant is issued whenever the
// single-entry result slot is free (empty, or being drained this cycle); the
// granted pair's sum lands in the result register on the same edge.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic [CNT_W-1:0] carry_cnt
);

  arb_state_t       state_q;
  arb_state_t       state_d;
  req_id_t          last_q;
  req_id_t          gnt_id;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  assign res_valid = (state_q == FULL);

  // Slot is free when nothing is held or the held result leaves this cycle;
  // grants are suppressed during reset so no pair is consumed then.
  always_comb begin
    slot_free = (state_q == EMPTY) || res_ready;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (!rst && slot_free) begin
      if (req0_valid && req1_valid) begin
        if (last_q == REQ1) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    grant  = grant0 | grant1;
    gnt_id = grant1 ? REQ1 : REQ0;
    op_a   = grant1 ? req1_a : req0_a;
    op_b   = grant1 ? req1_b : req0_b;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  add_core #(
    .WIDTH (WIDTH)
  ) u_add_core (
    .a     (op_a),
    .b     (op_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Slot FSM next state: fill on grant, drain on take without a refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (grant) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (res_ready && !grant) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Slot state and round-robin pointer; pointer moves only when a grant occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= REQ1;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q <= gnt_id;
      end
    end
  end

  // Result register and carry-event counter, loaded only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
      carry_cnt <= '0;
    end else if (grant) begin
      res_sum   <= add_sum;
      res_carry <= add_carry;
      res_id    <= gnt_id;
      if (add_carry) begin
        carry_cnt <= sat_inc(carry_cnt);
      end
    end
  end

endmodule : add_arbiter

// File: tb/tb_add_arbiter.sv
// Directed and randomized bench for add_arbiter against a transaction-level
// model of the result slot, round-robin preference and carry counter.
module tb_add_arbiter;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0;
  logic [W-1:0]  req0_a = '0;
  logic [W-1:0]  req0_b = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [W-1:0]  req1_a = '0;
  logic [W-1:0]  req1_b = '0;
  logic          req1_ready;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_sum;
  logic          res_carry;
  logic          res_id;
  logic [CW-1:0] carry_cnt;

  int errors = 0;
  int checks = 0;

  // Model state
  bit m_valid;
  int m_sum;
  int m_carry;
  int m_id;
  int m_cnt;
  int m_last;

  add_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id),
    .carry_cnt  (carry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_sum   = 0;
    m_carry = 0;
    m_id    = 0;
    m_cnt   = 0;
    m_last  = 1;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_valid"}, 32'(res_valid), 32'(m_valid));
    chk({tag, "_sum"},   32'(res_sum),   32'(m_sum));
    chk({tag, "_carry"}, 32'(res_carry), 32'(m_carry));
    chk({tag, "_id"},    32'(res_id),    32'(m_id));
    chk({tag, "_cnt"},   32'(carry_cnt), 32'(m_cnt));
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input string tag,
                       input bit v0, input int a0, input int b0,
                       input bit v1, input int a1, input int b1,
                       input bit rr);
    bit free;
    int win;
    int s;
    req0_valid = v0; req0_a = W'(a0); req0_b = W'(b0);
    req1_valid = v1; req1_a = W'(a1); req1_b = W'(b1);
    res_ready  = rr;
    #2;
    free = !m_valid || rr;
    win  = -1;
    if (free && v0 && v1) win = (m_last == 0) ? 1 : 0;
    else if (free && v0)  win = 0;
    else if (free && v1)  win = 1;
    chk_outputs(tag);
    chk({tag, "_rdy0"}, 32'(req0_ready), 32'(win == 0));
    chk({tag, "_rdy1"}, 32'(req1_ready), 32'(win == 1));
    @(posedge clk);
    #1;
    if (win >= 0) begin
      s = (win == 0) ? (a0 % 256) + (b0 % 256) : (a1 % 256) + (b1 % 256);
      m_sum   = s % (1 << W);
      m_carry = s / (1 << W);
      m_id    = win;
      m_last  = win;
      m_valid = 1'b1;
      if (m_carry == 1 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end else if (rr) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk_outputs("rst");
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_id [4];
    int exp_sum[4];
    exp_id  = '{0, 1, 0, 1};
    exp_sum = '{'h10, 'hFF, 'h10, 'hFF};

    do_reset();

    // Single requester 0: 1+1
    cycle("single", 1, 'h01, 'h01, 0, 0, 0, 0);
    chk("single_sum_const", 32'(res_sum), 32'h02);
    chk("single_id_const", 32'(res_id), 32'd0);
    chk("single_valid_const", 32'(res_valid), 32'd1);
    cycle("drain", 0, 0, 0, 0, 0, 0, 1);

    // Requester 1 overflow: FF+01
    cycle("carry", 0, 0, 0, 1, 'hFF, 'h01, 1);
    chk("carry_sum_const", 32'(res_sum), 32'h00);
    chk("carry_c_const", 32'(res_carry), 32'd1);
    chk("carry_id_const", 32'(res_id), 32'd1);
    chk("carry_cnt_const", 32'(carry_cnt), 32'd1);
    cycle("idle", 0, 0, 0, 0, 0, 0, 1);
    cycle("idle2", 0, 0, 0, 0, 0, 0, 1);

    // Tie round-robin from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle("tie", 1, 'h0F, 'h01, 1, 'hAA, 'h55, 1);
      chk("tie_id_const", 32'(res_id), 32'(exp_id[i]));
      chk("tie_sum_const", 32'(res_sum), 32'(exp_sum[i]));
    end

    // Backpressure: hold for 5 cycles, then release
    for (int i = 0; i < 5; i++) begin
      cycle("stall", 1, 'h0F, 'h01, 1, 'hAA, 'h55, 0);
    end
    cycle("release", 1, 'h0F, 'h01, 1, 'hAA, 'h55, 1);
    cycle("release2", 0, 0, 0, 0, 0, 0, 1);
    cycle("release3", 0, 0, 0, 0, 0, 0, 1);

    // Saturation of the carry counter
    for (int i = 0; i < 300; i++) begin
      cycle("sat", 1, 'hFF, 'h01, 0, 0, 0, 1);
    end
    chk("sat_cnt_const", 32'(carry_cnt), 32'hFF);

    // Asynchronous reset while a result is held
    cycle("pre_rst", 1, 'h12, 'h34, 0, 0, 0, 0);
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_cnt", 32'(carry_cnt), 32'd0);
    chk("arst_sum", 32'(res_sum), 32'd0);
    chk("arst_rdy0", 32'(req0_ready), 32'd0);
    chk("arst_rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle("post_rst", 0, 0, 0, 0, 0, 0, 0);
    cycle("post_rst2", 0, 0, 0, 0, 0, 0, 1);
    cycle("post_rst3", 0, 'h77, 'h11, 1, 'h80, 'h80, 0);
    cycle("post_rst4", 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_add_arbiter
